// File: rtl/eth_dds_pkg.sv
// Shared definitions for the DDS-configuration Ethernet record (sender and receiver).
// The record is five 32-bit words: wave, amplitude, frequency, min-resolution, phase.
package eth_dds_pkg;

    localparam int DDS_WORDS = 5;

    localparam logic [2:0] W_WAVE  = 3'd0;
    localparam logic [2:0] W_AMP   = 3'd1;
    localparam logic [2:0] W_FREQ  = 3'd2;
    localparam logic [2:0] W_MIN   = 3'd3;
    localparam logic [2:0] W_PHASE = 3'd4;
    localparam logic [2:0] W_FULL  = 3'd5;

    localparam int WAVE_W  = 4;
    localparam int AMP_W   = 9;
    localparam int FREQ_W  = 32;
    localparam int MIN_W   = 32;
    localparam int PHASE_W = 12;

    localparam logic [31:0] RSVD_MASK_WAVE  = 32'hFFFF_FFF0;
    localparam logic [31:0] RSVD_MASK_AMP   = 32'hFFFF_FE00;
    localparam logic [31:0] RSVD_MASK_PHASE = 32'hFFFF_F000;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_SHORT   = 2'd1;
    localparam logic [1:0] ERR_RSVD    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } dds_state_e;

    // Pad bits that must be zero for the word at a given record index.
    function automatic logic rsvd_hit(input logic [2:0] idx, input logic [31:0] word);
        logic hit;
        case (idx)
            W_WAVE:  hit = |(word & RSVD_MASK_WAVE);
            W_AMP:   hit = |(word & RSVD_MASK_AMP);
            W_PHASE: hit = |(word & RSVD_MASK_PHASE);
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/eth_recv_dds.sv
// Parses received UDP payloads as DDS configuration records and commits complete,
// well-formed records atomically to the DDS control outputs; bad packets are flagged.
module eth_recv_dds
    import eth_dds_pkg::*;
#(
    parameter logic [15:0]  TIMEOUT_CYC = 16'd4096,
    parameter logic         CHECK_RSVD  = 1'b1,
    parameter logic [3:0]   DEF_WAVE    = 4'd0,
    parameter logic [8:0]   DEF_AMP     = 9'd256,
    parameter logic [31:0]  DEF_FREQ    = 32'd0,
    parameter logic [31:0]  DEF_MIN     = 32'd0,
    parameter logic [11:0]  DEF_PHASE   = 12'd0
) (
    input  logic                 eth_rx_clk,
    input  logic                 rst,
    input  logic                 rec_en,
    input  logic [31:0]          rec_data,
    input  logic                 rec_pkt_done,
    input  logic [15:0]          rec_byte_num,
    output logic [WAVE_W-1:0]    wave_select,
    output logic [AMP_W-1:0]     amp_ctl,
    output logic [FREQ_W-1:0]    freq_ctl,
    output logic [MIN_W-1:0]     min_ctl,
    output logic [PHASE_W-1:0]   phase_ctl,
    output logic                 cfg_update,
    output logic                 rx_err,
    output logic [1:0]           rx_err_code,
    output logic [15:0]          pkt_ok_cnt,
    output logic [15:0]          pkt_err_cnt
);

    dds_state_e state_r, state_nx_s;

    logic [2:0]          word_cnt_r, word_cnt_nx_s, cnt_now_s;
    logic                bad_rsvd_r, bad_rsvd_nx_s, bad_now_s;
    logic [15:0]         idle_cnt_r, idle_cnt_nx_s;
    logic [WAVE_W-1:0]   sh_wave_r, sh_wave_nx_s, cap_wave_s;
    logic [AMP_W-1:0]    sh_amp_r, sh_amp_nx_s, cap_amp_s;
    logic [FREQ_W-1:0]   sh_freq_r, sh_freq_nx_s, cap_freq_s;
    logic [MIN_W-1:0]    sh_min_r, sh_min_nx_s, cap_min_s;
    logic [PHASE_W-1:0]  sh_phase_r, sh_phase_nx_s, cap_phase_s;
    logic                timeout_s, commit_s, discard_s;
    logic [1:0]          err_code_s;

    logic [WAVE_W-1:0]   wave_r;
    logic [AMP_W-1:0]    amp_r;
    logic [FREQ_W-1:0]   freq_r;
    logic [MIN_W-1:0]    min_r;
    logic [PHASE_W-1:0]  phase_r;
    logic                cfg_update_r, rx_err_r;
    logic [1:0]          rx_err_code_r;
    logic [15:0]         ok_cnt_r, err_cnt_r;

    // Byte count is informational; word count alone decides commit.
    logic unused_byte_num_s;
    assign unused_byte_num_s = ^rec_byte_num;

    // FSM state register.
    always_ff @(posedge eth_rx_clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state, word capture (a same-cycle word is folded in before pkt_done is judged).
    always_comb begin
        state_nx_s    = state_r;
        cnt_now_s     = word_cnt_r;
        bad_now_s     = bad_rsvd_r;
        cap_wave_s    = sh_wave_r;
        cap_amp_s     = sh_amp_r;
        cap_freq_s    = sh_freq_r;
        cap_min_s     = sh_min_r;
        cap_phase_s   = sh_phase_r;
        idle_cnt_nx_s = 16'd0;
        timeout_s     = 1'b0;

        if (rec_en) begin
            cnt_now_s = (word_cnt_r == W_FULL) ? W_FULL : word_cnt_r + 3'd1;
            bad_now_s = bad_rsvd_r | (CHECK_RSVD & rsvd_hit(word_cnt_r, rec_data));
            case (word_cnt_r)
                W_WAVE:  cap_wave_s  = rec_data[WAVE_W-1:0];
                W_AMP:   cap_amp_s   = rec_data[AMP_W-1:0];
                W_FREQ:  cap_freq_s  = rec_data;
                W_MIN:   cap_min_s   = rec_data;
                W_PHASE: cap_phase_s = rec_data[PHASE_W-1:0];
                default: cap_wave_s  = sh_wave_r;
            endcase
        end else begin
            cnt_now_s = word_cnt_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (rec_en && !rec_pkt_done) begin
                    state_nx_s = ST_RECV;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RECV: begin
                if (rec_en || rec_pkt_done) begin
                    idle_cnt_nx_s = 16'd0;
                end else begin
                    idle_cnt_nx_s = idle_cnt_r + 16'd1;
                end
                timeout_s = !rec_en && !rec_pkt_done && (idle_cnt_nx_s == TIMEOUT_CYC);
                if (rec_pkt_done || timeout_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_RECV;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Packet outcome and shadow/counter next values.
    always_comb begin
        commit_s   = rec_pkt_done && (cnt_now_s == W_FULL) && !bad_now_s;
        discard_s  = (rec_pkt_done && !commit_s) || timeout_s;
        err_code_s = ERR_NONE;
        if (timeout_s) begin
            err_code_s = ERR_TIMEOUT;
        end else if (cnt_now_s != W_FULL) begin
            err_code_s = ERR_SHORT;
        end else begin
            err_code_s = ERR_RSVD;
        end

        if (rec_pkt_done || timeout_s) begin
            word_cnt_nx_s = 3'd0;
            bad_rsvd_nx_s = 1'b0;
            sh_wave_nx_s  = '0;
            sh_amp_nx_s   = '0;
            sh_freq_nx_s  = '0;
            sh_min_nx_s   = '0;
            sh_phase_nx_s = '0;
        end else begin
            word_cnt_nx_s = cnt_now_s;
            bad_rsvd_nx_s = bad_now_s;
            sh_wave_nx_s  = cap_wave_s;
            sh_amp_nx_s   = cap_amp_s;
            sh_freq_nx_s  = cap_freq_s;
            sh_min_nx_s   = cap_min_s;
            sh_phase_nx_s = cap_phase_s;
        end
    end

    // Shadow registers, word counter and inter-word idle counter.
    always_ff @(posedge eth_rx_clk or posedge rst) begin
        if (rst) begin
            word_cnt_r <= 3'd0;
            bad_rsvd_r <= 1'b0;
            idle_cnt_r <= 16'd0;
            sh_wave_r  <= '0;
            sh_amp_r   <= '0;
            sh_freq_r  <= '0;
            sh_min_r   <= '0;
            sh_phase_r <= '0;
        end else begin
            word_cnt_r <= word_cnt_nx_s;
            bad_rsvd_r <= bad_rsvd_nx_s;
            idle_cnt_r <= idle_cnt_nx_s;
            sh_wave_r  <= sh_wave_nx_s;
            sh_amp_r   <= sh_amp_nx_s;
            sh_freq_r  <= sh_freq_nx_s;
            sh_min_r   <= sh_min_nx_s;
            sh_phase_r <= sh_phase_nx_s;
        end
    end

    // Committed configuration, status pulses and saturating packet counters.
    always_ff @(posedge eth_rx_clk or posedge rst) begin
        if (rst) begin
            wave_r        <= DEF_WAVE;
            amp_r         <= DEF_AMP;
            freq_r        <= DEF_FREQ;
            min_r         <= DEF_MIN;
            phase_r       <= DEF_PHASE;
            cfg_update_r  <= 1'b0;
            rx_err_r      <= 1'b0;
            rx_err_code_r <= ERR_NONE;
            ok_cnt_r      <= 16'd0;
            err_cnt_r     <= 16'd0;
        end else begin
            cfg_update_r <= commit_s;
            rx_err_r     <= discard_s;
            if (commit_s) begin
                wave_r   <= cap_wave_s;
                amp_r    <= cap_amp_s;
                freq_r   <= cap_freq_s;
                min_r    <= cap_min_s;
                phase_r  <= cap_phase_s;
                ok_cnt_r <= (ok_cnt_r == 16'hFFFF) ? ok_cnt_r : ok_cnt_r + 16'd1;
            end
            if (discard_s) begin
                rx_err_code_r <= err_code_s;
                err_cnt_r     <= (err_cnt_r == 16'hFFFF) ? err_cnt_r : err_cnt_r + 16'd1;
            end
        end
    end

    assign wave_select = wave_r;
    assign amp_ctl     = amp_r;
    assign freq_ctl    = freq_r;
    assign min_ctl     = min_r;
    assign phase_ctl   = phase_r;
    assign cfg_update  = cfg_update_r;
    assign rx_err      = rx_err_r;
    assign rx_err_code = rx_err_code_r;
    assign pkt_ok_cnt  = ok_cnt_r;
    assign pkt_err_cnt = err_cnt_r;

endmodule

// File: tb/tb_eth_recv_dds.sv
// Bench for eth_recv_dds: two instances (reserved check on/off) against a packet-level model.
module tb_eth_recv_dds;

    localparam int TMO = 16;

    logic        eth_rx_clk = 1'b0;
    logic        rst = 1'b1;
    logic        rec_en = 1'b0;
    logic [31:0] rec_data = 32'd0;
    logic        rec_pkt_done = 1'b0;
    logic [15:0] rec_byte_num = 16'd0;

    logic [3:0]  wave   [2];
    logic [8:0]  amp    [2];
    logic [31:0] freq   [2];
    logic [31:0] minr   [2];
    logic [11:0] phase  [2];
    logic        upd    [2];
    logic        err    [2];
    logic [1:0]  code   [2];
    logic [15:0] okc    [2];
    logic [15:0] errc   [2];

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    always #5 eth_rx_clk = ~eth_rx_clk;

    eth_recv_dds #(.TIMEOUT_CYC(16'd16), .CHECK_RSVD(1'b1)) dut0 (
        .eth_rx_clk(eth_rx_clk), .rst(rst), .rec_en(rec_en), .rec_data(rec_data),
        .rec_pkt_done(rec_pkt_done), .rec_byte_num(rec_byte_num),
        .wave_select(wave[0]), .amp_ctl(amp[0]), .freq_ctl(freq[0]), .min_ctl(minr[0]),
        .phase_ctl(phase[0]), .cfg_update(upd[0]), .rx_err(err[0]), .rx_err_code(code[0]),
        .pkt_ok_cnt(okc[0]), .pkt_err_cnt(errc[0]));

    eth_recv_dds #(.TIMEOUT_CYC(16'd16), .CHECK_RSVD(1'b0)) dut1 (
        .eth_rx_clk(eth_rx_clk), .rst(rst), .rec_en(rec_en), .rec_data(rec_data),
        .rec_pkt_done(rec_pkt_done), .rec_byte_num(rec_byte_num),
        .wave_select(wave[1]), .amp_ctl(amp[1]), .freq_ctl(freq[1]), .min_ctl(minr[1]),
        .phase_ctl(phase[1]), .cfg_update(upd[1]), .rx_err(err[1]), .rx_err_code(code[1]),
        .pkt_ok_cnt(okc[1]), .pkt_err_cnt(errc[1]));

    // Packet-level model: the words of the current packet are kept in a queue.
    logic [31:0] pq[$];
    bit          in_pkt;
    int          idle;
    logic [3:0]  e_wave  [2];
    logic [8:0]  e_amp   [2];
    logic [31:0] e_freq  [2];
    logic [31:0] e_min   [2];
    logic [11:0] e_phase [2];
    logic        e_upd   [2];
    logic        e_err   [2];
    logic [1:0]  e_code  [2];
    int          e_ok    [2];
    int          e_ec    [2];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        pq.delete();
        in_pkt = 1'b0;
        idle   = 0;
        for (int i = 0; i < 2; i++) begin
            e_wave[i] = 4'd0;  e_amp[i] = 9'd256; e_freq[i] = 32'd0; e_min[i] = 32'd0;
            e_phase[i] = 12'd0; e_upd[i] = 1'b0; e_err[i] = 1'b0; e_code[i] = 2'd0;
            e_ok[i] = 0; e_ec[i] = 0;
        end
    endtask

    task automatic model_fail(input int i, input logic [1:0] c);
        e_err[i]  = 1'b1;
        e_code[i] = c;
        if (e_ec[i] < 65535) e_ec[i]++;
    endtask

    task automatic model_end_packet();
        logic [31:0] w0, w1, w2, w3, w4;
        bit          bad;
        for (int i = 0; i < 2; i++) begin
            if (pq.size() < 5) begin
                model_fail(i, 2'd1);
            end else begin
                w0 = pq[0]; w1 = pq[1]; w2 = pq[2]; w3 = pq[3]; w4 = pq[4];
                bad = (i == 0) && (((w0 >> 4) != 0) || ((w1 >> 9) != 0) || ((w4 >> 12) != 0));
                if (bad) begin
                    model_fail(i, 2'd2);
                end else begin
                    e_wave[i] = w0[3:0]; e_amp[i] = w1[8:0]; e_freq[i] = w2;
                    e_min[i] = w3; e_phase[i] = w4[11:0]; e_upd[i] = 1'b1;
                    if (e_ok[i] < 65535) e_ok[i]++;
                end
            end
        end
        pq.delete();
        in_pkt = 1'b0;
        idle   = 0;
    endtask

    task automatic model_step(input logic en, input logic [31:0] d, input logic done);
        for (int i = 0; i < 2; i++) begin
            e_upd[i] = 1'b0;
            e_err[i] = 1'b0;
        end
        if (en) begin
            pq.push_back(d);
            in_pkt = 1'b1;
            idle   = 0;
        end
        if (done) begin
            model_end_packet();
        end else if (in_pkt && !en) begin
            idle++;
            if (idle == TMO) begin
                for (int i = 0; i < 2; i++) model_fail(i, 2'd3);
                pq.delete();
                in_pkt = 1'b0;
                idle   = 0;
            end
        end
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge eth_rx_clk) begin
        if (chk_on) begin
            for (int i = 0; i < 2; i++) begin
                cmp($sformatf("wave%0d", i),  {28'd0, wave[i]},  {28'd0, e_wave[i]});
                cmp($sformatf("amp%0d", i),   {23'd0, amp[i]},   {23'd0, e_amp[i]});
                cmp($sformatf("freq%0d", i),  freq[i],           e_freq[i]);
                cmp($sformatf("min%0d", i),   minr[i],           e_min[i]);
                cmp($sformatf("phase%0d", i), {20'd0, phase[i]}, {20'd0, e_phase[i]});
                cmp($sformatf("upd%0d", i),   {31'd0, upd[i]},   {31'd0, e_upd[i]});
                cmp($sformatf("err%0d", i),   {31'd0, err[i]},   {31'd0, e_err[i]});
                cmp($sformatf("code%0d", i),  {30'd0, code[i]},  {30'd0, e_code[i]});
                cmp($sformatf("okcnt%0d", i), {16'd0, okc[i]},   e_ok[i]);
                cmp($sformatf("errcnt%0d", i), {16'd0, errc[i]}, e_ec[i]);
            end
        end
    end

    task automatic step(input logic en, input logic [31:0] d, input logic done, input logic [15:0] bn);
        rec_en = en; rec_data = d; rec_pkt_done = done; rec_byte_num = bn;
        @(posedge eth_rx_clk);
        model_step(en, d, done);
        #1;
        rec_en = 1'b0; rec_pkt_done = 1'b0;
    endtask

    task automatic send5(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                         input logic [31:0] w3, input logic [31:0] w4, input bit done_last);
        step(1'b1, w0, 1'b0, 16'd0);
        step(1'b1, w1, 1'b0, 16'd0);
        step(1'b1, w2, 1'b0, 16'd0);
        step(1'b1, w3, 1'b0, 16'd0);
        step(1'b1, w4, done_last, 16'd20);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge eth_rx_clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        model_reset();
        #2 chk_on = 1'b1;
        repeat (2) @(posedge eth_rx_clk);
        #1 rst = 1'b0;
        cmp("lit_reset_wave", {28'd0, wave[0]}, 32'd0);
        cmp("lit_reset_amp", {23'd0, amp[0]}, 32'd256);

        // short packet: three words then pkt_done
        step(1'b1, 32'd3, 1'b0, 16'd0);
        step(1'b1, 32'h80, 1'b0, 16'd0);
        step(1'b1, 32'h0001_0000, 1'b0, 16'd0);
        step(1'b0, 32'd0, 1'b1, 16'd12);
        cmp("lit_short_err", {31'd0, err[0]}, 32'd1);
        cmp("lit_short_code", {30'd0, code[0]}, 32'd1);
        cmp("lit_short_errcnt", {16'd0, errc[0]}, 32'd1);
        cmp("lit_short_amp", {23'd0, amp[0]}, 32'd256);

        // good packet, pkt_done one cycle after the last word
        send5(32'd3, 32'h80, 32'h0001_0000, 32'h10, 32'h200, 1'b0);
        step(1'b0, 32'd0, 1'b1, 16'd20);
        cmp("lit_good_upd", {31'd0, upd[0]}, 32'd1);
        cmp("lit_good_wave", {28'd0, wave[0]}, 32'd3);
        cmp("lit_good_amp", {23'd0, amp[0]}, 32'h80);
        cmp("lit_good_freq", freq[0], 32'h0001_0000);
        cmp("lit_good_min", minr[0], 32'h10);
        cmp("lit_good_phase", {20'd0, phase[0]}, 32'h200);
        cmp("lit_good_okcnt", {16'd0, okc[0]}, 32'd1);
        step(1'b0, 32'd0, 1'b0, 16'd0);
        cmp("lit_good_upd_drop", {31'd0, upd[0]}, 32'd0);

        // 160-byte packet, words 5..39 all ones are ignored
        send5(32'd3, 32'h80, 32'h0001_0000, 32'h10, 32'h200, 1'b0);
        for (int k = 5; k < 39; k++) step(1'b1, 32'hFFFF_FFFF, 1'b0, 16'd0);
        step(1'b1, 32'hFFFF_FFFF, 1'b1, 16'd160);
        cmp("lit_pad_okcnt", {16'd0, okc[0]}, 32'd2);
        cmp("lit_pad_phase", {20'd0, phase[0]}, 32'h200);

        // reserved bit 4 set in word 0
        send5(32'h13, 32'h55, 32'h0001_0000, 32'h10, 32'h200, 1'b0);
        step(1'b0, 32'd0, 1'b1, 16'd20);
        cmp("lit_rsvd_code", {30'd0, code[0]}, 32'd2);
        cmp("lit_rsvd_keep_amp", {23'd0, amp[0]}, 32'h80);
        cmp("lit_norsvd_amp", {23'd0, amp[1]}, 32'h55);
        cmp("lit_norsvd_wave", {28'd0, wave[1]}, 32'd3);

        // timeout after two words, then a late pkt_done and a good packet
        step(1'b1, 32'd5, 1'b0, 16'd0);
        step(1'b1, 32'h44, 1'b0, 16'd0);
        for (int k = 1; k < TMO; k++) step(1'b0, 32'd0, 1'b0, 16'd0);
        cmp("lit_tmo_early", {31'd0, err[0]}, 32'd0);
        step(1'b0, 32'd0, 1'b0, 16'd0);
        cmp("lit_tmo_err", {31'd0, err[0]}, 32'd1);
        cmp("lit_tmo_code", {30'd0, code[0]}, 32'd3);
        step(1'b0, 32'd0, 1'b1, 16'd8);
        cmp("lit_late_done_code", {30'd0, code[0]}, 32'd1);
        send5(32'd7, 32'h1FF, 32'h1234_5678, 32'h9, 32'hFFF, 1'b0);
        step(1'b0, 32'd0, 1'b1, 16'd20);
        cmp("lit_after_tmo_ok", {16'd0, okc[0]}, 32'd3);
        cmp("lit_after_tmo_freq", freq[0], 32'h1234_5678);

        // reset in the middle of a packet, then a packet with pkt_done on word 5
        step(1'b1, 32'd3, 1'b0, 16'd0);
        step(1'b1, 32'h80, 1'b0, 16'd0);
        do_reset();
        cmp("lit_rst_wave", {28'd0, wave[0]}, 32'd0);
        cmp("lit_rst_err", {31'd0, err[0]}, 32'd0);
        cmp("lit_rst_errcnt", {16'd0, errc[0]}, 32'd0);
        send5(32'd2, 32'h11, 32'h0000_0100, 32'h20, 32'h3, 1'b1);
        cmp("lit_same_cycle_ok", {16'd0, okc[0]}, 32'd1);
        cmp("lit_same_cycle_phase", {20'd0, phase[0]}, 32'h3);
        step(1'b0, 32'd0, 1'b0, 16'd0);
        step(1'b0, 32'd0, 1'b0, 16'd0);

        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
